dot_product_accumulator: RTL



---
 rtl/dot_product_accumulator.sv | 99 +++++++++
 1 files changed

// File: rtl/dot_product_accumulator.sv
// Saturating dot-product accumulator: sums LEN unsigned products and holds the
// result behind a valid/ready handshake until the consumer takes it.
module dot_product_accumulator #(
   parameter int unsigned PROD_W = 16,
   parameter int unsigned ACC_W  = 18,
   parameter int unsigned LEN    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_sat,
   output logic [7:0]        term_cnt
);

   localparam logic [7:0] LAST_TERM = 8'(LEN - 1);

   typedef enum logic {StAccum, StHold} state_e;

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   out_sum_q, out_sum_d;
   logic               sat_q, sat_d;
   logic               out_sat_q, out_sat_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [ACC_W:0]     sum;
   logic [ACC_W-1:0]   acc_next;
   logic               sat_next;

   // One extra bit catches the carry out; saturation is sticky within a dot product.
   assign sum      = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
   assign sat_next = sum[ACC_W] | sat_q;
   assign acc_next = sat_next ? '1 : sum[ACC_W-1:0];

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      sat_d     = sat_q;
      cnt_d     = cnt_q;
      out_sum_d = out_sum_q;
      out_sat_d = out_sat_q;
      unique case (state_q)
         StAccum: begin
            if (clear) begin
               acc_d = '0;
               sat_d = 1'b0;
               cnt_d = '0;
            end else if (in_valid) begin
               if (cnt_q == LAST_TERM) begin
                  out_sum_d = acc_next;
                  out_sat_d = sat_next;
                  acc_d     = '0;
                  sat_d     = 1'b0;
                  cnt_d     = '0;
                  state_d   = StHold;
               end else begin
                  acc_d = acc_next;
                  sat_d = sat_next;
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         StHold: begin
            if (out_ready) state_d = StAccum;
         end
         default: state_d = StAccum;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StAccum;
         acc_q     <= '0;
         sat_q     <= 1'b0;
         cnt_q     <= '0;
         out_sum_q <= '0;
         out_sat_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         sat_q     <= sat_d;
         cnt_q     <= cnt_d;
         out_sum_q <= out_sum_d;
         out_sat_q <= out_sat_d;
      end
   end

   assign in_ready  = (state_q == StAccum);
   assign out_valid = (state_q == StHold);
   assign out_sum   = out_sum_q;
   assign out_sat   = out_sat_q;
   assign term_cnt  = cnt_q;

endmodule
